// File: rtl/uart_tx_ctrl_if.sv
// Register-side and line-side signals of the UART transmitter.
// Data memory drives DATA_R/CONFIG_R/BAUD_DIV and polls busy/done.
interface uart_tx_ctrl_if;
  logic [31:0] DATA_R;
  logic [31:0] CONFIG_R;
  logic [31:0] BAUD_DIV;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output DATA_R, CONFIG_R, BAUD_DIV, input tx, busy, done);
  modport slave  (input DATA_R, CONFIG_R, BAUD_DIV, output tx, busy, done);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmitter driven by memory-mapped DATA_R/CONFIG_R/BAUD_DIV words.
// Frame: start, 8 data bits LSB first, optional parity, one or two stop bits.
module uart_tx_ctrl #(
  parameter int unsigned DIV_W = 16
) (
  input logic           clk,
  input logic           reset,
  uart_tx_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic             start_q;
  logic [7:0]       data_q;
  logic             par_en_q;
  logic             par_odd_q;
  logic             two_stop_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;

  logic [DIV_W-1:0] div_in;
  logic             start_req;
  logic             bit_end;
  logic             unused;

  assign div_in    = bus.BAUD_DIV[DIV_W-1:0];
  assign start_req = bus.CONFIG_R[0] & ~start_q;
  assign bit_end   = (baud_cnt == div_q - DIV_W'(1));
  assign unused    = ^{bus.DATA_R, bus.CONFIG_R, bus.BAUD_DIV};

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      start_q    <= 1'b1;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      div_q      <= DIV_W'(1);
      baud_cnt   <= '0;
      bit_idx    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      start_q <= bus.CONFIG_R[0];
      done_q  <= 1'b0;
      // Baud counter is shared by all bit states; it restarts at each bit boundary.
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + DIV_W'(1);
      end
      case (state)
        IDLE: begin
          if (start_req) begin
            data_q     <= bus.DATA_R[7:0];
            par_en_q   <= bus.CONFIG_R[1];
            par_odd_q  <= bus.CONFIG_R[2];
            two_stop_q <= bus.CONFIG_R[3];
            div_q      <= (div_in == '0) ? DIV_W'(1) : div_in;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= data_q[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (par_en_q) begin
                tx_q  <= par_odd_q ? ~^data_q : ^data_q;
                state <= PARITY;
              end else begin
                tx_q  <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= data_q[bit_idx + 3'd1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_q  <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          // bit_idx marks the second stop bit so D never needs doubling in the counter.
          if (bit_end) begin
            if (two_stop_q && bit_idx == 3'd0) begin
              bit_idx <= 3'd1;
            end else begin
              bit_idx <= '0;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a frame-level model queues the expected
// per-cycle {tx,busy,done}; a monitor on the falling edge pops and compares.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(.DIV_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [2:0] exp_q[$];
  bit         model_start = 1'b1;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [31:0] cur_cfg = '0, cur_dat = '0, cur_baud = 32'd1;

  initial begin
    bus.CONFIG_R = '0;
    bus.DATA_R   = '0;
    bus.BAUD_DIV = 32'd1;
  end

  // Expected line activity of one frame, built from the framing rules.
  function automatic void push_frame(input logic [7:0] d, input logic [31:0] cfg,
                                     input logic [31:0] baud);
    int unsigned dlen;
    logic lv[$];
    dlen = (baud[15:0] == 16'd0) ? 1 : int'(baud[15:0]);
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(d[i]);
    if (cfg[1]) lv.push_back(cfg[2] ? ~^d : ^d);
    lv.push_back(1'b1);
    if (cfg[3]) lv.push_back(1'b1);
    foreach (lv[k])
      for (int unsigned j = 0; j < dlen; j++) exp_q.push_back({lv[k], 1'b1, 1'b0});
    exp_q.push_back(3'b101);
  endfunction

  always @(negedge clk) begin : monitor
    logic [2:0] e;
    logic [2:0] a;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b100;
    a = {bus.tx, bus.busy, bus.done};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL line {tx,busy,done} at %0t: got %b expected %b", $time, a, e);
    end
  end

  task automatic wait_slot();
    @(negedge clk);
    #1;
  endtask

  // Drive inputs for the coming edge and advance the model to match.
  task automatic apply(input logic r, input logic [31:0] c, input logic [31:0] d,
                       input logic [31:0] b);
    cur_cfg = c; cur_dat = d; cur_baud = b;
    reset = r;
    bus.CONFIG_R = c;
    bus.DATA_R   = d;
    bus.BAUD_DIV = b;
    if (r) begin
      exp_q.delete();
      model_start = 1'b1;
    end else begin
      if (c[0] && !model_start && exp_q.size() == 0) push_frame(d[7:0], c, b);
      model_start = c[0];
    end
  endtask

  task automatic tick(input logic [31:0] c, input logic [31:0] d, input logic [31:0] b);
    wait_slot();
    apply(1'b0, c, d, b);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick(cur_cfg, cur_dat, cur_baud);
  endtask

  initial begin
    // Reset with start held high through release: no frame.
    for (int i = 0; i < 3; i++) begin wait_slot(); apply(1'b1, 32'h1, 32'h12, 32'd2); end
    for (int i = 0; i < 6; i++) tick(32'h1, 32'h12, 32'd2);
    tick(32'h0, 32'h12, 32'd2);

    // 8N1, D=4, 0x55.
    tick(32'h1, 32'h55, 32'd4);
    hold(45);

    // Even then odd parity on 0x07.
    tick(32'h0, 32'h07, 32'd3);
    tick(32'h3, 32'h07, 32'd3);
    hold(36);
    tick(32'h0, 32'h07, 32'd3);
    tick(32'h7, 32'h07, 32'd3);
    hold(36);

    // Two stop bits, BAUD_DIV=0 treated as 1.
    tick(32'h0, 32'hC4, 32'd0);
    tick(32'h9, 32'hC4, 32'd0);
    hold(14);

    // Mid-frame start toggle and register changes; level held after done.
    tick(32'h0, 32'h3C, 32'd2);
    tick(32'h1, 32'h3C, 32'd2);
    hold(5);
    tick(32'h0, 32'hFF, 32'd2);
    hold(3);
    tick(32'hF, 32'hFF, 32'd7);
    hold(40);

    // Reset during data bit 3.
    tick(32'h0, 32'hA5, 32'd3);
    tick(32'h1, 32'hA5, 32'd3);
    hold(14);
    wait_slot(); apply(1'b1, 32'h1, 32'hA5, 32'd3);
    tick(32'h1, 32'hA5, 32'd3);
    hold(4);

    // Back-to-back: new request on the done cycle.
    tick(32'h0, 32'h81, 32'd2);
    tick(32'h1, 32'h81, 32'd2);
    tick(32'h0, 32'h81, 32'd2);
    for (int i = 0; i < 200; i++) begin
      wait_slot();
      if (exp_q.size() == 0) break;
      apply(1'b0, 32'h0, 32'h81, 32'd2);
    end
    apply(1'b0, 32'h1, 32'hA3, 32'd2);
    hold(26);

    // Randomised frames with perturbations and occasional reset.
    for (int f = 0; f < 30; f++) begin
      logic [31:0] c;
      c = {28'd0, $urandom_range(0, 7) * 2};
      tick(c, $urandom, $urandom_range(0, 5));
      tick(c | 32'h1, cur_dat, cur_baud);
      for (int n = 0, m = $urandom_range(5, 80); n < m; n++) begin
        if ($urandom_range(0, 199) == 0) begin
          wait_slot(); apply(1'b1, cur_cfg, cur_dat, cur_baud);
        end else if ($urandom_range(0, 7) == 0) begin
          tick({28'd0, 4'($urandom)}, $urandom, $urandom_range(0, 5));
        end else begin
          hold(1);
        end
      end
    end

    // Drain outstanding frames, then check nothing is left.
    tick(32'h0, cur_dat, cur_baud);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) hold(1);
    hold(3);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
